// File: rtl/iod_train_pkg.sv
// Shared types and constants for the reference-clock IOD training controller:
// FSM state encoding, eye-monitor wait length and a counter-width helper.
package iod_train_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StSettle,
    StCaptureRef,
    StSample,
    StStep,
    StEyeClr,
    StEyeWait,
    StNextLane,
    StDone
  } train_state_e;

  localparam int unsigned EYE_WAIT_CYC = 16;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned tap_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/iod_ref_clk_train_ctrl_if.sv
// Delay-line / eye-monitor / status bundle of the training controller.
// master = controller side, slave = delay-line and eye-monitor side.
interface iod_ref_clk_train_ctrl_if #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TAP_MAX    = 127
) ();
  import iod_train_pkg::*;

  localparam int unsigned TAP_W = tap_width(TAP_MAX);

  logic                            START;
  logic [NUM_LANES*DATA_WIDTH-1:0] RX_DATA;
  logic [NUM_LANES-1:0]            DELAY_LINE_OUT_OF_RANGE;
  logic [NUM_LANES-1:0]            EYE_MONITOR_EARLY;
  logic [NUM_LANES-1:0]            EYE_MONITOR_LATE;
  logic [NUM_LANES-1:0]            DELAY_LINE_MOVE;
  logic [NUM_LANES-1:0]            DELAY_LINE_DIRECTION;
  logic [NUM_LANES-1:0]            DELAY_LINE_LOAD;
  logic [NUM_LANES-1:0]            EYE_MONITOR_CLEAR_FLAGS;
  logic                            BUSY;
  logic                            DONE;
  logic [NUM_LANES-1:0]            LANE_ERR;
  logic [NUM_LANES*TAP_W-1:0]      LANE_TAP;

  modport master (
    input  START,
    input  RX_DATA,
    input  DELAY_LINE_OUT_OF_RANGE,
    input  EYE_MONITOR_EARLY,
    input  EYE_MONITOR_LATE,
    output DELAY_LINE_MOVE,
    output DELAY_LINE_DIRECTION,
    output DELAY_LINE_LOAD,
    output EYE_MONITOR_CLEAR_FLAGS,
    output BUSY,
    output DONE,
    output LANE_ERR,
    output LANE_TAP
  );

  modport slave (
    output START,
    output RX_DATA,
    output DELAY_LINE_OUT_OF_RANGE,
    output EYE_MONITOR_EARLY,
    output EYE_MONITOR_LATE,
    input  DELAY_LINE_MOVE,
    input  DELAY_LINE_DIRECTION,
    input  DELAY_LINE_LOAD,
    input  EYE_MONITOR_CLEAR_FLAGS,
    input  BUSY,
    input  DONE,
    input  LANE_ERR,
    input  LANE_TAP
  );

endinterface

// File: rtl/iod_train_edge_det.sv
// Edge detector shared by all lanes: holds the reference word W0 and counts
// consecutive samples that differ from it; flags the sample completing MATCH_CNT.
module iod_train_edge_det
  import iod_train_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MATCH_CNT  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic                  sample,
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  edge_found
);

  localparam int unsigned CntW = tap_width(MATCH_CNT);

  logic [DATA_WIDTH-1:0] w0_q, w0_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  always_comb begin
    w0_d       = w0_q;
    cnt_d      = cnt_q;
    edge_found = 1'b0;
    if (capture) begin
      w0_d  = word;
      cnt_d = '0;
    end else if (sample) begin
      if (word != w0_q) begin
        cnt_d      = cnt_q + 1'b1;
        edge_found = (cnt_q == CntW'(MATCH_CNT - 1));
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0_q  <= '0;
      cnt_q <= '0;
    end else begin
      w0_q  <= w0_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iod_ref_clk_train_ctrl.sv
// Reference-clock IOD delay training: sweeps each lane's delay line from tap 0 until the
// RX word changes stably. Optional eye-monitor check enabled by IOD_TRAIN_EYE_MON_EN.
module iod_ref_clk_train_ctrl
  import iod_train_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TAP_MAX    = 127,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned MATCH_CNT  = 3
) (
  input logic                      FAB_CLK,
  input logic                      ARST_N,
  iod_ref_clk_train_ctrl_if.master bus
);

  localparam int unsigned TAP_W = tap_width(TAP_MAX);
  localparam int unsigned LaneW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned SetW  = tap_width(SETTLE_CYC);

  train_state_e               state_q, state_d;
  logic [LaneW-1:0]           lane_q, lane_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic [SetW-1:0]            settle_q, settle_d;
  logic                       after_step_q, after_step_d;
  logic                       done_q, done_d;
  logic [NUM_LANES-1:0]       lane_err_q, lane_err_d;
  logic [NUM_LANES*TAP_W-1:0] lane_tap_q, lane_tap_d;

  logic [NUM_LANES-1:0]  lane_oh;
  logic [DATA_WIDTH-1:0] lane_word;
  logic                  oor;
  logic                  edge_found;

  assign lane_oh   = NUM_LANES'(1) << lane_q;
  assign lane_word = bus.RX_DATA[lane_q*DATA_WIDTH +: DATA_WIDTH];
  assign oor       = bus.DELAY_LINE_OUT_OF_RANGE[lane_q];

`ifdef IOD_TRAIN_EYE_MON_EN
  localparam int unsigned EyeW = $clog2(EYE_WAIT_CYC);

  logic [EyeW-1:0] eye_q, eye_d;
  logic            eye_flag;

  assign eye_flag = bus.EYE_MONITOR_EARLY[lane_q] | bus.EYE_MONITOR_LATE[lane_q];
  assign bus.EYE_MONITOR_CLEAR_FLAGS = (state_q == StEyeClr) ? lane_oh : '0;
`else
  logic unused_eye;

  assign unused_eye = ^{bus.EYE_MONITOR_EARLY, bus.EYE_MONITOR_LATE};
  assign bus.EYE_MONITOR_CLEAR_FLAGS = '0;
`endif

  iod_train_edge_det #(
    .DATA_WIDTH (DATA_WIDTH),
    .MATCH_CNT  (MATCH_CNT)
  ) u_edge_det (
    .clk        (FAB_CLK),
    .rst_n      (ARST_N),
    .capture    (state_q == StCaptureRef),
    .sample     (state_q == StSample),
    .word       (lane_word),
    .edge_found (edge_found)
  );

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    tap_d        = tap_q;
    settle_d     = settle_q;
    after_step_d = after_step_q;
    done_d       = done_q;
    lane_err_d   = lane_err_q;
    lane_tap_d   = lane_tap_q;
`ifdef IOD_TRAIN_EYE_MON_EN
    eye_d        = eye_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.START) begin
          done_d     = 1'b0;
          lane_err_d = '0;
          lane_tap_d = '0;
          lane_d     = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        tap_d        = '0;
        settle_d     = '0;
        after_step_d = 1'b0;
        state_d      = StSettle;
      end
      StSettle: begin
        if (settle_q == SetW'(SETTLE_CYC - 1)) begin
          settle_d = '0;
          state_d  = after_step_q ? StSample : StCaptureRef;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StCaptureRef: state_d = StStep;
      StStep: begin
        tap_d        = tap_q + 1'b1;
        settle_d     = '0;
        after_step_d = 1'b1;
        state_d      = StSettle;
      end
      StSample: begin
        // Out-of-range wins over an edge confirmed on the same sample.
        if (oor) begin
          lane_err_d[lane_q]                 = 1'b1;
          lane_tap_d[lane_q*TAP_W +: TAP_W]  = '0;
          state_d                            = StNextLane;
        end else if (edge_found) begin
          // The edge sits at the first of the MATCH_CNT differing taps.
          lane_tap_d[lane_q*TAP_W +: TAP_W] = tap_q - TAP_W'(MATCH_CNT - 1);
`ifdef IOD_TRAIN_EYE_MON_EN
          state_d = StEyeClr;
`else
          state_d = StNextLane;
`endif
        end else if (tap_q == TAP_W'(TAP_MAX)) begin
          lane_err_d[lane_q]                 = 1'b1;
          lane_tap_d[lane_q*TAP_W +: TAP_W]  = '0;
          state_d                            = StNextLane;
        end else begin
          state_d = StStep;
        end
      end
`ifdef IOD_TRAIN_EYE_MON_EN
      StEyeClr: begin
        eye_d   = '0;
        state_d = StEyeWait;
      end
      StEyeWait: begin
        if (eye_flag) lane_err_d[lane_q] = 1'b1;
        if (eye_q == EyeW'(EYE_WAIT_CYC - 1)) begin
          state_d = StNextLane;
        end else begin
          eye_d = eye_q + 1'b1;
        end
      end
`else
      StEyeClr:  state_d = StNextLane;
      StEyeWait: state_d = StNextLane;
`endif
      StNextLane: begin
        if (lane_q == LaneW'(NUM_LANES - 1)) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          lane_d  = lane_q + 1'b1;
          state_d = StLoad;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q      <= StIdle;
      lane_q       <= '0;
      tap_q        <= '0;
      settle_q     <= '0;
      after_step_q <= 1'b0;
      done_q       <= 1'b0;
      lane_err_q   <= '0;
      lane_tap_q   <= '0;
`ifdef IOD_TRAIN_EYE_MON_EN
      eye_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      tap_q        <= tap_d;
      settle_q     <= settle_d;
      after_step_q <= after_step_d;
      done_q       <= done_d;
      lane_err_q   <= lane_err_d;
      lane_tap_q   <= lane_tap_d;
`ifdef IOD_TRAIN_EYE_MON_EN
      eye_q        <= eye_d;
`endif
    end
  end

  // Commands decode from the state register so reset silences them at once.
  assign bus.DELAY_LINE_LOAD      = (state_q == StLoad) ? lane_oh : '0;
  assign bus.DELAY_LINE_MOVE      = (state_q == StStep) ? lane_oh : '0;
  assign bus.DELAY_LINE_DIRECTION = (state_q == StStep) ? lane_oh : '0;
  assign bus.BUSY                 = (state_q != StIdle) && (state_q != StDone);
  assign bus.DONE                 = done_q;
  assign bus.LANE_ERR             = lane_err_q;
  assign bus.LANE_TAP             = lane_tap_q;

endmodule
